// File: rtl/apb_xbar_port_arbiter.sv
// apb_xbar_port_arbiter: round-robin arbiter and APB sequencer in front of one completer port.
module apb_xbar_port_arbiter #(
   parameter int N_REQ   = 3,
   parameter int ADDR_W  = 60,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_write,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          req_done,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_slverr,
   output logic [1:0]                grant_id,
   output logic                      busy,
   output logic                      m_psel,
   output logic                      m_penable,
   output logic                      m_pwrite,
   output logic [ADDR_W-1:0]         m_paddr,
   output logic [DATA_W-1:0]         m_pwdata,
   input  logic                      m_pready,
   input  logic [DATA_W-1:0]         m_prdata,
   input  logic                      m_pslverr
);
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [2:0] NQ = 3'(N_REQ);
   localparam logic [1:0] LAST = 2'(N_REQ - 1);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t r_state, w_next;
   logic [1:0] r_ptr, w_off, w_sel;
   logic [2:0] w_sum, w_wrap;
   logic [2*N_REQ-1:0] w_rot;
   logic [CW-1:0] r_cnt;
   logic w_to, w_fin;
   logic [ADDR_W-1:0] w_addr [N_REQ];
   logic [DATA_W-1:0] w_wdata [N_REQ];
   genvar g;
   generate
      for (g = 0; g < N_REQ; g++) begin : g_req
         assign w_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
         assign w_wdata[g] = req_wdata[g*DATA_W +: DATA_W];
      end
   endgenerate
   // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
   assign w_rot = {req_valid, req_valid} >> r_ptr;
   always_comb begin
      w_off = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (w_rot[i]) w_off = 2'(i);
   end
   assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_wrap = w_sum - NQ;
   assign w_sel  = w_sum >= NQ ? w_wrap[1:0] : w_sum[1:0];
   assign w_to   = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
   assign w_fin  = (r_state == ACCESS) && (m_pready || w_to);
   assign m_psel    = r_state != IDLE;
   assign m_penable = r_state == ACCESS;
   assign busy      = m_psel;
   always_comb begin
      w_next = r_state;
      w_next = r_state == IDLE  ? (|req_valid ? SETUP : IDLE) :
               r_state == SETUP ? ACCESS :
               (w_fin ? IDLE : ACCESS);
   end
   always_ff @(posedge pclk) begin
      if (preset) r_state <= IDLE;
      else        r_state <= w_next;
   end
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_ptr      <= '0;
         r_cnt      <= '0;
         grant_id   <= '0;
         m_pwrite   <= 1'b0;
         m_paddr    <= '0;
         m_pwdata   <= '0;
         req_done   <= '0;
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b0;
      end else begin
         req_done <= '0;
         if (r_state == IDLE && |req_valid) begin
            grant_id <= w_sel;
            m_pwrite <= req_write[w_sel];
            m_paddr  <= w_addr[w_sel];
            m_pwdata <= w_wdata[w_sel];
         end
         if (r_state == SETUP) r_cnt <= '0;
         else if (r_state == ACCESS && !w_fin) r_cnt <= r_cnt + 1'b1;
         // A watchdog expiry completes as an error with no read data.
         if (w_fin) begin
            req_done   <= N_REQ'(1) << grant_id;
            rsp_rdata  <= (m_pready && !m_pwrite) ? m_prdata : '0;
            rsp_slverr <= m_pready ? m_pslverr : 1'b1;
            r_ptr      <= grant_id == LAST ? 2'd0 : grant_id + 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_apb_xbar_port_arbiter.sv
// tb_apb_xbar_port_arbiter: directed stimulus with a completion scoreboard checked by a monitor.
module tb_apb_xbar_port_arbiter;
   localparam int N = 3, AW = 60, DW = 32;
   typedef struct packed {
      logic [N-1:0]  done;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;
   logic pclk = 0, preset = 1;
   logic [N-1:0] req_valid = '0, req_write = '0, req_done;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [DW-1:0] rsp_rdata, m_pwdata, m_prdata = '0;
   logic rsp_slverr, busy, m_psel, m_penable, m_pwrite, m_pready, m_pslverr = 0;
   logic [1:0] grant_id;
   logic [AW-1:0] m_paddr;
   int n_chk = 0, n_fail = 0, cyc = 0, acc_cnt = 0, wait_n = 0, pc;
   bit hang = 0;
   exp_t sb[$];
   int done_cyc[$];

   apb_xbar_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
      .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
      .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .grant_id(grant_id), .busy(busy),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
      .m_pwdata(m_pwdata), .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr));

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;
   // Completer model: ready on the (wait_n+1)-th ACCESS cycle unless hung.
   always @(posedge pclk) acc_cnt <= m_penable ? acc_cnt + 1 : 0;
   assign m_pready = !hang && m_penable && acc_cnt == wait_n;

   always @(negedge pclk) begin
      if (req_done != '0) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done got done=%b rdata=%h err=%b with empty scoreboard", req_done, rsp_rdata, rsp_slverr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({req_done, rsp_rdata, rsp_slverr} !== e) begin
               n_fail++;
               $display("FAIL completion got done=%b rdata=%h err=%b expected done=%b rdata=%h err=%b",
                        req_done, rsp_rdata, rsp_slverr, e.done, e.rdata, e.err);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [N-1:0] d, input logic [DW-1:0] r, input logic e);
      exp_t x;
      x.done = d; x.rdata = r; x.err = e;
      sb.push_back(x);
   endtask

   // Each requester drops its request on seeing its own done pulse.
   task automatic run(input int budget, output int pen);
      pen = 0;
      for (int c = 0; c < budget && req_valid != '0; c++) begin
         @(negedge pclk);
         if (m_penable) pen++;
         if (req_done != '0) done_cyc.push_back(cyc);
         req_valid = req_valid & ~req_done;
      end
      chk("run_budget_outstanding", 64'(req_valid), 64'd0);
      req_valid = '0;
   endtask

   initial begin
      repeat (2) @(posedge pclk);
      #1 preset = 0;
      @(negedge pclk);
      chk("rst_psel", 64'(m_psel), 0);
      chk("rst_penable", 64'(m_penable), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(req_done), 0);
      chk("rst_grant", 64'(grant_id), 0);
      chk("rst_rdata_err", 64'({rsp_rdata, rsp_slverr}), 0);

      @(posedge pclk); #1;
      m_prdata = 32'hFFFF_0000;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW] = 60'(64'h100 * (i + 1));
         req_wdata[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
      end
      req_write = 3'b111; req_valid = 3'b111;
      push(3'b001, 0, 0); push(3'b010, 0, 0); push(3'b100, 0, 0);
      done_cyc.delete();
      run(100, pc);
      chk("rr1_pen_cycles", 64'(pc), 3);
      chk("rr1_gap01", 64'(done_cyc[1] - done_cyc[0]), 3);
      chk("rr1_gap12", 64'(done_cyc[2] - done_cyc[1]), 3);

      @(posedge pclk); #1;
      m_prdata = 32'h1111_2222; req_write = 3'b000; req_valid = 3'b111;
      push(3'b001, 32'h1111_2222, 0); push(3'b010, 32'h1111_2222, 0); push(3'b100, 32'h1111_2222, 0);
      run(100, pc);
      chk("rr2_pen_cycles", 64'(pc), 3);

      @(posedge pclk); #1;
      req_addr[1*AW +: AW] = 60'h0123_4567_89AB_CDE;
      req_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
      req_write = 3'b010; req_valid = 3'b010;
      push(3'b010, 0, 0);
      @(negedge pclk);
      chk("wr_idle_psel", 64'(m_psel), 0);
      @(negedge pclk);
      chk("wr_setup_psel_pen", 64'({m_psel, m_penable}), 64'b10);
      chk("wr_setup_paddr", 64'(m_paddr), 64'h0123_4567_89AB_CDE);
      chk("wr_setup_pwdata", 64'(m_pwdata), 64'hDEAD_BEEF);
      chk("wr_setup_pwrite_grant", 64'({m_pwrite, grant_id}), 64'b101);
      chk("wr_setup_busy", 64'(busy), 1);
      req_addr[1*AW +: AW] = '0;
      req_wdata[1*DW +: DW] = '0;
      @(negedge pclk);
      chk("wr_access_psel_pen", 64'({m_psel, m_penable}), 64'b11);
      chk("wr_access_paddr_stable", 64'(m_paddr), 64'h0123_4567_89AB_CDE);
      chk("wr_access_pwdata_stable", 64'(m_pwdata), 64'hDEAD_BEEF);
      run(10, pc);
      chk("wr_done_psel", 64'(m_psel), 0);

      @(posedge pclk); #1;
      wait_n = 3; m_prdata = 32'hA5A5_0001; req_write = 3'b000; req_valid = 3'b100;
      push(3'b100, 32'hA5A5_0001, 0);
      run(50, pc);
      chk("rd_wait_pen_cycles", 64'(pc), 4);
      wait_n = 0;

      @(posedge pclk); #1;
      hang = 1; m_prdata = 32'h5555_AAAA; req_valid = 3'b001;
      push(3'b001, 0, 1);
      run(100, pc);
      chk("timeout_pen_cycles", 64'(pc), 17);
      chk("timeout_psel_after", 64'(m_psel), 0);
      hang = 0;

      @(posedge pclk); #1;
      m_pslverr = 1; req_write = 3'b010; req_valid = 3'b010;
      push(3'b010, 0, 1);
      run(20, pc);
      m_pslverr = 0;

      @(posedge pclk); #1;
      hang = 1; req_write = 3'b000; req_valid = 3'b100;
      repeat (4) @(negedge pclk);
      chk("abort_in_access", 64'({m_psel, m_penable}), 64'b11);
      preset = 1; req_valid = '0;
      @(negedge pclk);
      chk("abort_psel_pen", 64'({m_psel, m_penable}), 0);
      chk("abort_grant", 64'(grant_id), 0);
      preset = 0; hang = 0;
      repeat (3) @(negedge pclk);
      @(posedge pclk); #1;
      req_write = 3'b101; req_valid = 3'b101;
      push(3'b001, 0, 0); push(3'b100, 0, 0);
      run(50, pc);
      chk("abort_next_pen_cycles", 64'(pc), 2);

      repeat (3) @(negedge pclk);
      chk("scoreboard_empty", 64'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout reached at cycle %0d", cyc);
      $fatal(1, "global timeout");
   end
endmodule

// File: doc/apb_xbar_port_arbiter.md
Name: apb_xbar_port_arbiter

Overview:
Per-completer arbiter and APB sequencer for the crossbar interconnect. One instance sits in front of each completer port. It collects transfer requests from the requester ports (IDs 0..N_REQ-1) and grants the completer round-robin. It runs the APB setup/access sequence on the completer side and routes the response back to the granted requester. A wait-state watchdog terminates hung transfers with an error.

Parameters:
N_REQ, 3, number of requester ports (2..4)
ADDR_W, 60, address width (28-bit high plus 32-bit low)
DATA_W, 32, data width
TIMEOUT, 16, maximum ACCESS cycles with pready low before forced error completion; 0 disables the watchdog

Ports:
pclk  in  1  clock
preset  in  1  reset, synchronous, active-high
req_valid  in  N_REQ  per-requester transfer request for this completer
req_write  in  N_REQ  per-requester direction, 1=write 0=read
req_addr  in  N_REQ*ADDR_W  per-requester address, requester i at slice i
req_wdata  in  N_REQ*DATA_W  per-requester write data
req_done  out  N_REQ  one-cycle completion pulse to the granted requester
rsp_rdata  out  DATA_W  read data, valid while req_done is high
rsp_slverr  out  1  error flag, valid while req_done is high
grant_id  out  2  currently granted requester; holds the last grant when idle
busy  out  1  high in SETUP and ACCESS
m_psel  out  1  APB select to completer
m_penable  out  1  APB enable to completer
m_pwrite  out  1  APB direction
m_paddr  out  ADDR_W  APB address
m_pwdata  out  DATA_W  APB write data
m_pready  in  1  completer ready
m_prdata  in  DATA_W  completer read data
m_pslverr  in  1  completer error

Behaviour:
- Reset values, forced at the first pclk edge with preset=1:
  - state=IDLE; all m_* outputs, req_done, rsp_rdata, rsp_slverr, grant_id and busy are 0.
  - Round-robin pointer=0; wait counter=0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, select the first set bit, searching upward from the pointer with wrap-around modulo N_REQ.
  - Latch that requester's write, addr and wdata into the m_* registers; set grant_id; go to SETUP.
  - If no request is set, stay in IDLE with psel=0.
- SETUP (exactly 1 cycle): m_psel=1, m_penable=0; go to ACCESS.
- ACCESS: m_psel=1, m_penable=1.
  - If m_pready=1: assert req_done[grant_id] for this cycle only (registered, visible the cycle after the pready edge sample). Capture rsp_rdata=m_prdata (reads; 0 for writes) and rsp_slverr=m_pslverr. Set pointer=(grant_id+1) mod N_REQ; go to IDLE.
  - Else, if TIMEOUT!=0 and the wait counter reaches TIMEOUT: complete as above with rsp_slverr=1 and rsp_rdata=0.
  - Else: increment the wait counter. The counter clears on entering ACCESS.
- Latency: a request sampled in IDLE at edge k gives SETUP in cycle k+1 and ACCESS in cycle k+2. With zero wait states, req_done pulses in cycle k+3. After completion the block returns to IDLE for at least 1 cycle, so a transfer occupies at least 3 cycles per grant.
- Transfer payload is latched at grant. m_paddr, m_pwrite and m_pwdata stay stable from SETUP through completion, regardless of requester-side changes.
- A requester holds req_valid until it sees its req_done. If req_valid drops after grant, the transfer still completes and req_done still pulses. A requester that keeps req_valid high after req_done is treated as a new request.
- Simultaneous requests are serviced in pointer order. No requester waits more than N_REQ-1 grants.
- req_done, rsp_rdata and rsp_slverr change only on completion cycles. rsp_* hold their values until the next completion.
- Reset asserted mid-transfer: at the next edge, psel and penable drop to 0, the FSM goes to IDLE and the pointer goes to 0. No req_done is issued for the aborted transfer.
- grant_id is zero-extended when N_REQ<4. Requester indices >= N_REQ do not exist.

Test Plan:
- Single write: req 1 writes addr 0x0123_4567_89AB_CDE, data 0xDEADBEEF, pready=1 immediately -> psel in cycles k+1 and k+2, penable in cycle k+2, m_paddr/m_pwdata equal the request values, req_done=3'b010 for 1 cycle, rsp_slverr=0.
- All three requests in the same cycle, zero wait states -> grants in order 0,1,2, each completion 3 cycles apart. A second simultaneous round after the pointer reaches 0 again -> order 0,1,2.
- Read with wait states: req 2 reads, pready low for 3 ACCESS cycles then high with prdata=0xA5A5_0001 -> penable high for 4 cycles, rsp_rdata=0xA5A5_0001, req_done=3'b100.
- Timeout: pready held low, TIMEOUT=16 -> completion after 17 ACCESS cycles with rsp_slverr=1 and rsp_rdata=0, then psel=0.
- Error pass-through: pslverr=1 together with pready=1 -> rsp_slverr=1 on the req_done cycle.
- Reset mid-ACCESS: preset=1 for 1 cycle with pready low -> psel=0 and penable=0 at the next edge, no req_done. The next simultaneous request from 0 and 2 grants 0 first.
